// File: rtl/ultrasonic_echo_timer.sv
// Periodic ultrasonic ranging front end: fires the sensor trigger, times the echo pulse
// in aclk cycles and hands each result to the measurement buffer over valid/ready.
module ultrasonic_echo_timer #(
    parameter int COUNT_W            = 25,
    parameter int TRIG_CYCLES        = 1000,
    parameter int TIMEOUT_CYCLES     = 3800000,
    parameter int MEAS_PERIOD_CYCLES = 6000000
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               enable,
    input  logic               echo_in,
    output logic               trig_out,
    output logic [COUNT_W-1:0] meas_data,
    output logic               meas_timeout,
    output logic               meas_valid,
    input  logic               meas_ready,
    output logic               busy
);

    localparam int TRIG_W = $clog2(TRIG_CYCLES + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PER_W  = $clog2(MEAS_PERIOD_CYCLES + 1);

    localparam logic [TRIG_W-1:0]  TRIG_LAST     = TRIG_W'(TRIG_CYCLES - 1);
    localparam logic [TO_W-1:0]    TIMEOUT_LIMIT = TO_W'(TIMEOUT_CYCLES);
    localparam logic [PER_W-1:0]   PERIOD_LAST   = PER_W'(MEAS_PERIOD_CYCLES - 1);
    localparam logic [COUNT_W-1:0] WIDTH_MAX     = '1;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        OUTPUT,
        HOLDOFF
    } state_t;

    state_t             state_q;
    logic               echoS1_q;
    logic               echoS2_q;
    logic [TRIG_W-1:0]  trigCnt_q;
    logic [TO_W-1:0]    timeoutCnt_q;
    logic [PER_W-1:0]   periodCnt_q;
    logic [COUNT_W-1:0] widthCnt_q;
    logic               trigOut_q;
    logic [COUNT_W-1:0] measData_q;
    logic               measTimeout_q;
    logic               measValid_q;

    // echo_in is asynchronous to aclk; only the second stage feeds the controller.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            echoS1_q <= 1'b0;
            echoS2_q <= 1'b0;
        end else begin
            echoS1_q <= echo_in;
            echoS2_q <= echoS1_q;
        end
    end

    // Measurement controller. The period counter saturates so a long back-pressure
    // stall simply defers the next trigger until the pending result has been taken.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q       <= IDLE;
            trigCnt_q     <= '0;
            timeoutCnt_q  <= '0;
            periodCnt_q   <= '0;
            widthCnt_q    <= '0;
            trigOut_q     <= 1'b0;
            measData_q    <= '0;
            measTimeout_q <= 1'b0;
            measValid_q   <= 1'b0;
        end else begin
            if (periodCnt_q != PERIOD_LAST) begin
                periodCnt_q <= periodCnt_q + PER_W'(1);
            end

            case (state_q)
                IDLE: begin
                    if (enable && !echoS2_q) begin
                        state_q     <= TRIG;
                        trigOut_q   <= 1'b1;
                        trigCnt_q   <= '0;
                        periodCnt_q <= '0;
                    end
                end

                TRIG: begin
                    if (trigCnt_q == TRIG_LAST) begin
                        state_q      <= WAIT_RISE;
                        trigOut_q    <= 1'b0;
                        timeoutCnt_q <= '0;
                    end else begin
                        trigCnt_q <= trigCnt_q + TRIG_W'(1);
                    end
                end

                WAIT_RISE: begin
                    if (timeoutCnt_q == TIMEOUT_LIMIT) begin
                        state_q       <= OUTPUT;
                        measData_q    <= WIDTH_MAX;
                        measTimeout_q <= 1'b1;
                        measValid_q   <= 1'b1;
                    end else begin
                        timeoutCnt_q <= timeoutCnt_q + TO_W'(1);
                        if (echoS2_q) begin
                            state_q    <= MEASURE;
                            widthCnt_q <= COUNT_W'(1);
                        end
                    end
                end

                // Timeout wins over a falling edge seen in the same cycle.
                MEASURE: begin
                    if (timeoutCnt_q == TIMEOUT_LIMIT) begin
                        state_q       <= OUTPUT;
                        measData_q    <= WIDTH_MAX;
                        measTimeout_q <= 1'b1;
                        measValid_q   <= 1'b1;
                    end else begin
                        timeoutCnt_q <= timeoutCnt_q + TO_W'(1);
                        if (echoS2_q) begin
                            if (widthCnt_q != WIDTH_MAX) begin
                                widthCnt_q <= widthCnt_q + COUNT_W'(1);
                            end
                        end else begin
                            state_q       <= OUTPUT;
                            measData_q    <= widthCnt_q;
                            measTimeout_q <= 1'b0;
                            measValid_q   <= 1'b1;
                        end
                    end
                end

                OUTPUT: begin
                    if (meas_ready) begin
                        state_q     <= HOLDOFF;
                        measValid_q <= 1'b0;
                    end
                end

                HOLDOFF: begin
                    if (periodCnt_q == PERIOD_LAST) begin
                        if (!enable) begin
                            state_q <= IDLE;
                        end else if (!echoS2_q) begin
                            state_q     <= TRIG;
                            trigOut_q   <= 1'b1;
                            trigCnt_q   <= '0;
                            periodCnt_q <= '0;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign trig_out     = trigOut_q;
    assign meas_data    = measData_q;
    assign meas_timeout = measTimeout_q;
    assign meas_valid   = measValid_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_ultrasonic_echo_timer.sv
// Directed bench for ultrasonic_echo_timer: nominal, no echo, stuck echo, back-pressure,
// mid-measurement reset and enable drop, with small trigger/timeout/period values.
module tb_ultrasonic_echo_timer;

    localparam int W       = 25;
    localparam int TRIG    = 10;
    localparam int TIMEOUT = 200;
    localparam int PERIOD  = 500;

    logic         aclk = 1'b0;
    logic         areset;
    logic         enable;
    logic         echo_in;
    logic         meas_ready;
    logic         trig_out;
    logic [W-1:0] meas_data;
    logic         meas_timeout;
    logic         meas_valid;
    logic         busy;

    int assertCount = 0;
    int failCount   = 0;

    int   cyc            = 0;
    int   trigRiseCount  = 0;
    int   trigFallCount  = 0;
    int   validRiseCount = 0;
    int   trigRiseCyc    = 0;
    int   trigFallCyc    = 0;
    int   validRiseCyc   = 0;
    int   trigHighLen    = 0;
    int   lastTrigLen    = 0;
    logic prevTrig       = 1'b0;
    logic prevValid      = 1'b0;

    ultrasonic_echo_timer #(
        .COUNT_W           (W),
        .TRIG_CYCLES       (TRIG),
        .TIMEOUT_CYCLES    (TIMEOUT),
        .MEAS_PERIOD_CYCLES(PERIOD)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .enable      (enable),
        .echo_in     (echo_in),
        .trig_out    (trig_out),
        .meas_data   (meas_data),
        .meas_timeout(meas_timeout),
        .meas_valid  (meas_valid),
        .meas_ready  (meas_ready),
        .busy        (busy)
    );

    always #5 aclk = ~aclk;

    // Edge stamps are taken just after each rising edge, so cyc names the edge that caused them.
    always @(posedge aclk) begin
        #1;
        cyc++;
        if (trig_out && !prevTrig) begin
            trigRiseCyc = cyc;
            trigRiseCount++;
            trigHighLen = 0;
        end
        if (trig_out) trigHighLen++;
        if (!trig_out && prevTrig) begin
            trigFallCyc = cyc;
            lastTrigLen = trigHighLen;
            trigFallCount++;
        end
        if (meas_valid && !prevValid) begin
            validRiseCyc = cyc;
            validRiseCount++;
        end
        prevTrig  = trig_out;
        prevValid = meas_valid;
    end

    initial begin
        #200us;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int delay, input int width);
        repeat (delay) @(negedge aclk);
        echo_in = 1'b1;
        repeat (width) @(negedge aclk);
        echo_in = 1'b0;
    endtask

    task automatic waitTrigRise(input string tag, input int budget);
        int start = trigRiseCount;
        int n = 0;
        while (trigRiseCount == start && n < budget) begin
            @(negedge aclk);
            n++;
        end
        checkOutput(tag, 32'(trigRiseCount != start), 1);
    endtask

    task automatic waitTrigFall(input string tag, input int budget);
        int start = trigFallCount;
        int n = 0;
        while (trigFallCount == start && n < budget) begin
            @(negedge aclk);
            n++;
        end
        checkOutput(tag, 32'(trigFallCount != start), 1);
    endtask

    task automatic waitValidRise(input string tag, input int budget);
        int start = validRiseCount;
        int n = 0;
        while (validRiseCount == start && n < budget) begin
            @(negedge aclk);
            n++;
        end
        checkOutput(tag, 32'(validRiseCount != start), 1);
    endtask

    initial begin
        int rise1, rise2, rise3, rise5, rise6, c, mark, errs;

        areset     = 1'b1;
        enable     = 1'b0;
        echo_in    = 1'b0;
        meas_ready = 1'b0;
        repeat (3) @(negedge aclk);
        checkOutput("rstTrig", 32'(trig_out), 0);
        checkOutput("rstData", 32'(meas_data), 0);
        checkOutput("rstTimeout", 32'(meas_timeout), 0);
        checkOutput("rstValid", 32'(meas_valid), 0);
        checkOutput("rstBusy", 32'(busy), 0);

        // Nominal 57-cycle echo
        areset     = 1'b0;
        enable     = 1'b1;
        meas_ready = 1'b1;
        waitTrigRise("nomRiseSeen", 5);
        rise1 = trigRiseCyc;
        waitTrigFall("nomFallSeen", 20);
        checkOutput("nomTrigLen", lastTrigLen, TRIG);
        applyStimulus(20, 57);
        c = cyc;
        waitValidRise("nomValidSeen", 10);
        checkOutput("nomLatency", validRiseCyc - c, 3);
        checkOutput("nomData", 32'(meas_data), 57);
        checkOutput("nomTimeout", 32'(meas_timeout), 0);
        @(negedge aclk);
        checkOutput("nomValidDrop", 32'(meas_valid), 0);

        // No echo at all
        waitTrigRise("noEchoRiseSeen", 600);
        rise2 = trigRiseCyc;
        checkOutput("period1", rise2 - rise1, PERIOD);
        waitTrigFall("noEchoFallSeen", 20);
        checkOutput("noEchoTrigLen", lastTrigLen, TRIG);
        waitValidRise("noEchoValidSeen", 250);
        checkOutput("noEchoLatency", validRiseCyc - trigFallCyc, TIMEOUT + 1);
        checkOutput("noEchoData", 32'(meas_data), 32'h1FF_FFFF);
        checkOutput("noEchoTimeout", 32'(meas_timeout), 1);

        // Echo longer than the timeout and still high when the period ends
        waitTrigRise("longRiseSeen", 600);
        rise3 = trigRiseCyc;
        checkOutput("period2", rise3 - rise2, PERIOD);
        waitTrigFall("longFallSeen", 20);
        repeat (20) @(negedge aclk);
        echo_in = 1'b1;
        waitValidRise("longValidSeen", 250);
        checkOutput("longLatency", validRiseCyc - trigFallCyc, TIMEOUT + 1);
        checkOutput("longData", 32'(meas_data), 32'h1FF_FFFF);
        checkOutput("longTimeout", 32'(meas_timeout), 1);
        mark = trigRiseCount;
        while (cyc < rise3 + PERIOD + 20) @(negedge aclk);
        checkOutput("stuckNoTrig", trigRiseCount, mark);
        checkOutput("stuckBusy", 32'(busy), 1);
        echo_in = 1'b0;
        c = cyc;
        waitTrigRise("stuckReleaseSeen", 10);
        checkOutput("stuckReleaseWithin3", 32'((trigRiseCyc - c) <= 3), 1);

        // Consumer stalls well past the period end
        waitTrigFall("bpFallSeen", 20);
        meas_ready = 1'b0;
        applyStimulus(20, 30);
        waitValidRise("bpValidSeen", 10);
        checkOutput("bpData", 32'(meas_data), 30);
        mark = trigRiseCount;
        errs = 0;
        repeat (600) begin
            @(negedge aclk);
            if (meas_valid !== 1'b1 || meas_data !== W'(30) || meas_timeout !== 1'b0) errs++;
        end
        checkOutput("bpStable", errs, 0);
        checkOutput("bpNoTrig", trigRiseCount, mark);
        meas_ready = 1'b1;
        c = cyc;
        @(negedge aclk);
        checkOutput("bpValidDrop", 32'(meas_valid), 0);
        waitTrigRise("bpRiseSeen", 5);
        checkOutput("bpTrigDelay", trigRiseCyc - c, 2);

        // Asynchronous reset in the middle of an echo
        waitTrigFall("rstFallSeen", 20);
        repeat (20) @(negedge aclk);
        echo_in = 1'b1;
        repeat (10) @(negedge aclk);
        #2 areset = 1'b1;
        #1;
        checkOutput("midRstTrig", 32'(trig_out), 0);
        checkOutput("midRstData", 32'(meas_data), 0);
        checkOutput("midRstTimeout", 32'(meas_timeout), 0);
        checkOutput("midRstValid", 32'(meas_valid), 0);
        checkOutput("midRstBusy", 32'(busy), 0);
        echo_in = 1'b0;
        repeat (3) @(negedge aclk);
        areset = 1'b0;
        waitTrigRise("postRstRiseSeen", 5);
        rise5 = trigRiseCyc;
        waitTrigFall("postRstFallSeen", 20);
        checkOutput("postRstTrigLen", lastTrigLen, TRIG);
        applyStimulus(20, 45);
        waitValidRise("postRstValidSeen", 10);
        checkOutput("postRstData", 32'(meas_data), 45);
        checkOutput("postRstTimeout", 32'(meas_timeout), 0);

        // enable dropped while the echo is being timed
        waitTrigRise("enRiseSeen", 600);
        rise6 = trigRiseCyc;
        checkOutput("period3", rise6 - rise5, PERIOD);
        waitTrigFall("enFallSeen", 20);
        repeat (20) @(negedge aclk);
        echo_in = 1'b1;
        repeat (10) @(negedge aclk);
        enable = 1'b0;
        repeat (30) @(negedge aclk);
        echo_in = 1'b0;
        waitValidRise("enValidSeen", 10);
        checkOutput("enData", 32'(meas_data), 40);
        checkOutput("enTimeout", 32'(meas_timeout), 0);
        mark = trigRiseCount;
        while (cyc < rise6 + PERIOD + 5) @(negedge aclk);
        checkOutput("enIdleBusy", 32'(busy), 0);
        checkOutput("enIdleTrig", 32'(trig_out), 0);
        repeat (600) @(negedge aclk);
        checkOutput("enNoTrig", trigRiseCount, mark);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/ultrasonic_echo_timer.md
Name: ultrasonic_echo_timer

Overview:
- Upstream stage of the measurement buffer. Periodically fires the ultrasonic sensor trigger and times the width of the returned echo pulse in aclk cycles.
- Delivers one 25-bit count per measurement over a valid/ready handshake into the buffer's write side.
- Handles echo timeout, a stuck-high echo and consumer back-pressure without losing a result.

Parameters:
- COUNT_W, 25: result width; matches buffer word width.
- TRIG_CYCLES, 1000: trigger pulse length (10 us at 100 MHz).
- TIMEOUT_CYCLES, 3800000: maximum wait from trigger end to echo fall (38 ms). Must be < 2^COUNT_W-1.
- MEAS_PERIOD_CYCLES, 6000000: trigger-to-trigger spacing (60 ms). Must be > TRIG_CYCLES+TIMEOUT_CYCLES+4.

Ports:
- aclk  in  1  system clock.
- areset  in  1  asynchronous reset, active-high.
- enable  in  1  run measurements while high.
- echo_in  in  1  raw sensor echo, asynchronous to aclk.
- trig_out  out  1  sensor trigger pulse, registered.
- meas_data  out  COUNT_W  echo width in aclk cycles; all-ones on timeout.
- meas_timeout  out  1  qualifies meas_data as a timeout result.
- meas_valid  out  1  result available.
- meas_ready  in  1  consumer accepts result.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0. Reset is asynchronous and may assert mid-operation: trig_out drops immediately and any pending result is discarded.
- echo_in passes through a 2-flop synchronizer (s1→s2). Only s2 is used by the control logic.
- States: IDLE, TRIG, WAIT_RISE, MEASURE, OUTPUT, HOLDOFF.
- IDLE → TRIG when enable=1 and s2=0. If s2=1 (echo stuck high), remain in IDLE.
- TRIG:
  - trig_out=1 for exactly TRIG_CYCLES cycles.
  - Period counter clears to 0 on TRIG entry and then increments every cycle until the next TRIG entry.
  - After TRIG_CYCLES cycles → WAIT_RISE; trig_out=0 and the timeout counter clears.
- WAIT_RISE: timeout counter increments each cycle. If s2=1 → MEASURE, width counter loaded with 1.
- MEASURE:
  - While s2=1, the width counter increments (saturating at 2^COUNT_W-1) and the timeout counter keeps running.
  - If s2=0 → OUTPUT with meas_data=width, meas_timeout=0.
- Timeout: in WAIT_RISE or MEASURE, when the timeout counter reaches TIMEOUT_CYCLES → OUTPUT with meas_data=all ones and meas_timeout=1. This takes priority over an echo edge in the same cycle.
- Latency: if echo_in is driven synchronously high for exactly N sampled cycles, meas_data=N exactly. meas_valid is high after the 3rd aclk edge, counting the first edge that samples echo_in low.
- OUTPUT:
  - meas_valid=1; meas_data and meas_timeout stay stable until meas_ready=1.
  - Transfer happens on a cycle with valid&ready; meas_valid drops on the following edge → HOLDOFF.
  - There is no combinational path from meas_ready to meas_valid.
- HOLDOFF: wait until the period counter reaches MEAS_PERIOD_CYCLES-1, then:
  - → TRIG if enable=1 and s2=0;
  - → IDLE if enable=0;
  - stay in HOLDOFF if s2=1.
- Back-pressure: if the period elapses while still in OUTPUT, the next trigger is deferred until after the transfer. The period counter saturates and results are never dropped or overwritten.
- enable is sampled only in IDLE and at HOLDOFF exit. Deasserting it mid-measurement lets the current result complete and transfer.
- Trigger-to-trigger spacing is exactly MEAS_PERIOD_CYCLES when meas_ready is held high and echo returns low in time.

Test Plan:
Use TRIG_CYCLES=10, TIMEOUT_CYCLES=200, MEAS_PERIOD_CYCLES=500 for all scenarios.
- Nominal: enable=1, meas_ready=1, echo high 57 cycles starting 20 cycles after trig_out falls → trig_out high exactly 10 cycles; one meas_valid pulse with meas_data=57, meas_timeout=0; next trig_out rise exactly 500 cycles after the first.
- No echo: echo_in held 0 → meas_data=0x1FFFFFF, meas_timeout=1, meas_valid 201 cycles after trig_out falls (200 timeout + 1 registered).
- Long echo: echo high 300 cycles → timeout result (all ones, meas_timeout=1). Echo still high at HOLDOFF end → no trigger until echo low, then trig_out within 3 cycles.
- Back-pressure: meas_ready=0 for 600 cycles after meas_valid → meas_data stable throughout; no trig_out; result transferred when ready rises; trig_out follows the next cycle.
- Reset mid-operation: areset pulse during MEASURE → all outputs 0 asynchronously; after release with enable=1, a clean measurement reports the correct width.
- Enable drop: enable=0 during MEASURE → result of 40 still delivered, then IDLE with busy=0 and no further triggers.
